// File: rtl/error_eval_pkg.sv
// Shared definitions for the error evaluation sequencer.
// Contents: default widths, the sequencer state enum and the all-ones
// pattern used to saturate the error accumulator.
package error_eval_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_ACC_W  = 28;

  // Wide all-ones pattern; users slice it down to their accumulator width.
  localparam logic [63:0] SAT_ONES = {64{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_KICK  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ACC   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/abs_sat_acc.sv
// Absolute-value saturating accumulator.
// Converts a signed error word to its unsigned magnitude and adds it into a
// sum that sticks at all-ones once it overflows.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear of the sum (has priority over en)
//   en        - add |err| into the sum this cycle
//   err       - signed error word (two's complement)
//   mag       - combinational |err|, DATA_W-bit unsigned
//   sum       - registered saturating sum
module abs_sat_acc
  import error_eval_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] err,
  output logic [DATA_W-1:0] mag,
  output logic [ACC_W-1:0]  sum
);

  localparam logic [ACC_W-1:0] SAT_VAL = SAT_ONES[ACC_W-1:0];

  // Unsigned magnitude; the most negative input maps to 2^(DATA_W-1),
  // which is still representable as an unsigned DATA_W value.
  function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1]) begin
      abs_mag = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      abs_mag = v;
    end
  endfunction

  logic [ACC_W-1:0] sum_r;
  logic [ACC_W:0]   sum_ext_s;
  logic [ACC_W-1:0] sum_nxt_s;

  assign mag = abs_mag(err);

  // One-bit-wider add exposes the carry used to detect overflow.
  always_comb begin
    sum_ext_s = {1'b0, sum_r} + {{(ACC_W + 1 - DATA_W){1'b0}}, mag};
    if (sum_ext_s[ACC_W]) begin
      sum_nxt_s = SAT_VAL;
    end else begin
      sum_nxt_s = sum_ext_s[ACC_W-1:0];
    end
  end

  // Sum register: clear on a new sweep, accumulate when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r <= {ACC_W{1'b0}};
    end else if (clr) begin
      sum_r <= {ACC_W{1'b0}};
    end else if (en) begin
      sum_r <= sum_nxt_s;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/error_eval_sequencer.sv
// Error evaluation sequencer.
// Walks sample memory 0..n_points-1, hands each (X, Y) pair to the error
// checker through its start/ready handshake and accumulates |error| into a
// saturating sum.
// Optional feature macro: ERR_MAX_TRACK_EN builds the largest-|error|
// tracker (max_err/max_idx); otherwise those outputs are tied to zero.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   go, n_points       - sweep request and point count (captured on accept)
//   mem_rd, mem_addr   - sample memory read; mem_x/mem_y valid next cycle
//   ec_x, ec_y         - registered operands to the error checker
//   ec_start           - one-cycle start pulse to the checker
//   ec_ready, ec_err   - checker result handshake and signed error
//   busy, done         - sweep in progress / one-cycle completion pulse
//   sum_err            - saturating sum of |error|
//   max_err, max_idx   - largest |error| and its index
module error_eval_sequencer
  import error_eval_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W:0]   n_points,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_x,
  input  logic [DATA_W-1:0] mem_y,
  output logic [DATA_W-1:0] ec_x,
  output logic [DATA_W-1:0] ec_y,
  output logic              ec_start,
  input  logic              ec_ready,
  input  logic [DATA_W-1:0] ec_err,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum_err,
  output logic [DATA_W-1:0] max_err,
  output logic [ADDR_W-1:0] max_idx
);

  localparam logic [ADDR_W:0] NPTS_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [ADDR_W:0]   n_cap_r;
  logic [DATA_W-1:0] err_r;
  logic [DATA_W-1:0] mag_s;
  logic              go_ok_s, last_s, acc_en_s;
  logic              mem_rd_r, ec_start_r, busy_r, done_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] ec_x_r, ec_y_r;

  assign go_ok_s  = (state_r == ST_IDLE) && go;
  assign acc_en_s = (state_r == ST_ACC);
  // Compare in ADDR_W+1 bits so n_points = 2^ADDR_W ends at idx 2^ADDR_W-1
  // instead of wrapping the address counter.
  assign last_s   = ({1'b0, idx_r} == (n_cap_r - NPTS_ONE));

  // Next-state and next-index logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (go) begin
          idx_s = {ADDR_W{1'b0}};
          if (n_points == {(ADDR_W + 1){1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: state_s = ST_LATCH;
      ST_LATCH: state_s = ST_KICK;
      ST_KICK:  state_s = ST_WAIT;  // ready seen here is stale and ignored
      ST_WAIT: begin
        if (ec_ready) begin
          state_s = ST_ACC;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ACC: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          idx_s   = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_s = ST_FETCH;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, index and captured point count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {ADDR_W{1'b0}};
      n_cap_r <= {(ADDR_W + 1){1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (go_ok_s) begin
        n_cap_r <= n_points;
      end
    end
  end

  // Registered outputs decoded from the upcoming state so each strobe is
  // high exactly during the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      ec_start_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      mem_rd_r   <= (state_s == ST_FETCH);
      ec_start_r <= (state_s == ST_KICK);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
      if (state_s == ST_FETCH) begin
        mem_addr_r <= idx_s;
      end
    end
  end

  // Operand capture in LATCH and error capture on the WAIT-cycle ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ec_x_r <= {DATA_W{1'b0}};
      ec_y_r <= {DATA_W{1'b0}};
      err_r  <= {DATA_W{1'b0}};
    end else begin
      if (state_r == ST_LATCH) begin
        ec_x_r <= mem_x;
        ec_y_r <= mem_y;
      end
      if ((state_r == ST_WAIT) && ec_ready) begin
        err_r <= ec_err;
      end
    end
  end

  abs_sat_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (go_ok_s),
    .en  (acc_en_s),
    .err (err_r),
    .mag (mag_s),
    .sum (sum_err)
  );

`ifdef ERR_MAX_TRACK_EN
  logic [DATA_W-1:0] max_err_r;
  logic [ADDR_W-1:0] max_idx_r;

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_err_r <= {DATA_W{1'b0}};
      max_idx_r <= {ADDR_W{1'b0}};
    end else if (go_ok_s) begin
      max_err_r <= {DATA_W{1'b0}};
      max_idx_r <= {ADDR_W{1'b0}};
    end else if (acc_en_s && (mag_s > max_err_r)) begin
      max_err_r <= mag_s;
      max_idx_r <= idx_r;
    end
  end

  assign max_err = max_err_r;
  assign max_idx = max_idx_r;
`else
  assign max_err = {DATA_W{1'b0}};
  assign max_idx = {ADDR_W{1'b0}};
`endif

  assign mem_rd   = mem_rd_r;
  assign mem_addr = mem_addr_r;
  assign ec_x     = ec_x_r;
  assign ec_y     = ec_y_r;
  assign ec_start = ec_start_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_error_eval_sequencer.sv
// Self-checking bench for error_eval_sequencer.
// A sweep-level model turns (n_points, WAIT length, error table) into the
// per-cycle expected outputs; one compare process checks them every cycle
// a sweep is active. Stub memory and stub error checker drive the inputs.
// Literal expectations after each sweep pin the model.
module tb_error_eval_sequencer;

  localparam int DW = 20;
  localparam int AW = 8;
  localparam int CW = 24;
  localparam longint SAT = (64'd1 << CW) - 64'd1;
  localparam int PMAX = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW:0]   n_points;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_x, mem_y;
  logic [DW-1:0] ec_x, ec_y;
  logic          ec_start;
  logic          ec_ready;
  logic [DW-1:0] ec_err;
  logic          busy, done;
  logic [CW-1:0] sum_err;
  logic [DW-1:0] max_err;
  logic [AW-1:0] max_idx;

  error_eval_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(CW)) dut (
    .clk(clk), .rst(rst), .go(go), .n_points(n_points),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
    .ec_x(ec_x), .ec_y(ec_y), .ec_start(ec_start), .ec_ready(ec_ready),
    .ec_err(ec_err), .busy(busy), .done(done), .sum_err(sum_err),
    .max_err(max_err), .max_idx(max_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]        xmem [256];
  logic [DW-1:0]        ymem [256];
  logic signed [DW-1:0] err_tab [256];
  int  k_cfg = 1;
  bit  cont_ready = 1'b0;

  // Per-cycle expectations, indexed by cycle after the accepting edge.
  bit            e_busy [PMAX];
  bit            e_rd [PMAX];
  bit            e_start [PMAX];
  bit            e_done [PMAX];
  int            e_addr [PMAX];
  logic [DW-1:0] e_x [PMAX];
  logic [DW-1:0] e_y [PMAX];
  longint        e_sum [PMAX];
  longint        e_max [PMAX];
  int            e_mi [PMAX];
  int  plan_len = 0;
  int  rel = 0;
  bit  plan_on = 1'b0;
  int  rd_cnt = 0, st_cnt = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fill(input int c, input bit b, input longint s, input longint mx, input int mi);
    e_busy[c] = b; e_rd[c] = 1'b0; e_start[c] = 1'b0; e_done[c] = 1'b0;
    e_addr[c] = 0; e_sum[c] = s; e_max[c] = mx; e_mi[c] = mi;
  endtask

  // Sweep model: each point is FETCH, LATCH, KICK, k WAIT cycles, ACC;
  // results become visible the cycle after ACC; done follows the last ACC.
  task automatic build_plan(input int n, input int k);
    int t; longint s, mx, a; int mi;
    t = 0; s = 0; mx = 0; mi = 0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4 + k; c++) fill(t + c, 1'b1, s, mx, mi);
      e_rd[t] = 1'b1; e_addr[t] = i;
      e_start[t + 2] = 1'b1; e_x[t + 2] = xmem[i]; e_y[t + 2] = ymem[i];
      a = err_tab[i];
      if (a < 0) a = -a;
      s = s + a;
      if (s > SAT) s = SAT;
      if (a > mx) begin mx = a; mi = i; end
      t = t + 4 + k;
    end
    fill(t, 1'b1, s, mx, mi);
    e_done[t] = 1'b1;
    for (int c = 1; c <= 3; c++) fill(t + c, 1'b0, s, mx, mi);
    plan_len = t + 3;
  endtask

  // Stub memory (data one cycle after mem_rd) and stub error checker
  // (ready k WAIT cycles after the start pulse, error valid only then).
  int cnt = 0, pt = 0, pend_addr = 0;
  bit rd_pend = 1'b0, valid;
  always @(negedge clk) begin
    if (!rst) begin
      cnt = 0; pt = 0; rd_pend = 1'b0;
      mem_x = '0; mem_y = '0; ec_ready = 1'b0; ec_err = '0;
    end else begin
      if (rd_pend) begin
        mem_x = xmem[pend_addr]; mem_y = ymem[pend_addr];
      end else begin
        mem_x = 20'hABCDE; mem_y = 20'h5A5A5;
      end
      rd_pend = mem_rd; pend_addr = int'(mem_addr);
      if (!busy) pt = 0;
      valid = 1'b0;
      if (ec_start) begin
        cnt = k_cfg; pt = pt + 1;
      end else if (cnt > 0) begin
        cnt = cnt - 1; valid = (cnt == 0);
      end
      ec_ready = cont_ready ? 1'b1 : valid;
      ec_err = valid ? err_tab[pt - 1] : 20'h7FFFF;
    end
  end

  // Compare process: DUT outputs against the model on every active cycle.
  always @(negedge clk) begin
    if (rst && plan_on) begin
      chk("busy", busy, e_busy[rel]);
      chk("mem_rd", mem_rd, e_rd[rel]);
      if (e_rd[rel]) chk("mem_addr", mem_addr, e_addr[rel]);
      chk("ec_start", ec_start, e_start[rel]);
      if (e_start[rel]) begin
        chk("ec_x", ec_x, e_x[rel]);
        chk("ec_y", ec_y, e_y[rel]);
      end
      chk("done", done, e_done[rel]);
      chk("sum_err", sum_err, e_sum[rel]);
`ifdef ERR_MAX_TRACK_EN
      chk("max_err", max_err, e_max[rel]);
      chk("max_idx", max_idx, e_mi[rel]);
`else
      chk("max_err", max_err, 0);
      chk("max_idx", max_idx, 0);
`endif
      rel++;
      if (rel > plan_len) plan_on = 1'b0;
    end
    if (mem_rd) rd_cnt++;
    if (ec_start) st_cnt++;
    if (done) done_cnt++;
  end

  // Issue go for one cycle; returns in the first cycle after acceptance.
  task automatic run_go(input int n, input int k, input bit cont);
    @(posedge clk); #2;
    k_cfg = k; cont_ready = cont; n_points = n[AW:0]; go = 1'b1;
    build_plan(n, k);
    @(posedge clk); #2;
    go = 1'b0; rel = 0; plan_on = 1'b1;
  endtask

  task automatic wait_plan();
    for (int i = 0; i < 3000; i++) begin
      if (!plan_on) break;
      @(posedge clk);
    end
    #2;
    chk("sweep_timeout", plan_on, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mem_rd"}, mem_rd, 0);     chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " ec_x"}, ec_x, 0);         chk({tag, " ec_y"}, ec_y, 0);
    chk({tag, " ec_start"}, ec_start, 0); chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);         chk({tag, " sum_err"}, sum_err, 0);
    chk({tag, " max_err"}, max_err, 0);   chk({tag, " max_idx"}, max_idx, 0);
  endtask

  int lat, snap_rd, snap_st, snap_done;

  initial begin
    rst = 1'b0; go = 1'b0; n_points = '0;
    for (int i = 0; i < 256; i++) begin
      xmem[i] = DW'(i * 3); ymem[i] = DW'(i + 7); err_tab[i] = 20'sd0;
    end
    #12;
    chk_zero("reset");
    @(posedge clk); #2; rst = 1'b1;

    // Three points, k=2: |2|+|-5|+|1| = 8, done in cycle 20 counting go as 1.
    xmem[0] = 20'd1; xmem[1] = 20'd2; xmem[2] = 20'd3;
    ymem[0] = 20'd1; ymem[1] = 20'd4; ymem[2] = 20'd9;
    err_tab[0] = 20'sd2; err_tab[1] = -20'sd5; err_tab[2] = 20'sd1;
    run_go(3, 2, 1'b0);
    lat = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); lat++;
      if (done) break;
    end
    chk("A latency", lat, 20);
    wait_plan();
    chk("A sum", sum_err, 8);
`ifdef ERR_MAX_TRACK_EN
    chk("A max_err", max_err, 5); chk("A max_idx", max_idx, 1);
`else
    chk("A max_err", max_err, 0); chk("A max_idx", max_idx, 0);
`endif

    // Zero points: done next cycle, no reads, no starts.
    snap_rd = rd_cnt; snap_st = st_cnt;
    run_go(0, 1, 1'b0);
    chk("B done", done, 1);
    wait_plan();
    chk("B sum", sum_err, 0);
    chk("B rd_count", rd_cnt - snap_rd, 0);
    chk("B start_count", st_cnt - snap_st, 0);

    // Ready held high: stale ready in KICK ignored, 5 cycles per point,
    // and a second go mid-sweep with a different count is ignored.
    err_tab[0] = 20'sd7; err_tab[1] = -20'sd3; err_tab[2] = 20'sd100; err_tab[3] = -20'sd1;
    run_go(4, 1, 1'b1);
    repeat (3) @(posedge clk);
    #2; go = 1'b1; n_points = 9'd9;
    @(posedge clk); #2; go = 1'b0;
    wait_plan();
    chk("C sum", sum_err, 111);
    cont_ready = 1'b0;

    // Reset during WAIT of the second point (k=3: cycle 11 after accept).
    err_tab[0] = 20'sd10; err_tab[1] = 20'sd20; err_tab[2] = 20'sd30;
    run_go(3, 3, 1'b0);
    repeat (11) @(posedge clk);
    #2; chk("D pre-reset busy", busy, 1);
    #1; rst = 1'b0; plan_on = 1'b0;
    #1; chk_zero("abort");
    snap_done = done_cnt;
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    repeat (20) @(posedge clk);
    #2; chk("D no done", done_cnt - snap_done, 0);
    chk("D idle busy", busy, 0);
    run_go(3, 2, 1'b0);
    wait_plan();
    chk("D restart sum", sum_err, 60);

    // Ties keep the lowest index.
    err_tab[0] = 20'sd4; err_tab[1] = 20'sd4; err_tab[2] = -20'sd4;
    run_go(3, 2, 1'b0);
    wait_plan();
    chk("E sum", sum_err, 12);
`ifdef ERR_MAX_TRACK_EN
    chk("E max_err", max_err, 4); chk("E max_idx", max_idx, 0);
`else
    chk("E max_err", max_err, 0); chk("E max_idx", max_idx, 0);
`endif

    // Full 256-point sweep of -2^19: saturates after 32 points, never wraps.
    for (int i = 0; i < 256; i++) err_tab[i] = 20'sh80000;
    snap_rd = rd_cnt;
    run_go(256, 1, 1'b0);
    wait_plan();
    chk("F sum", sum_err, 24'hFFFFFF);
    chk("F rd_count", rd_cnt - snap_rd, 256);
`ifdef ERR_MAX_TRACK_EN
    chk("F max_err", max_err, 20'h80000); chk("F max_idx", max_idx, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
